data_mem_responder: RTL and testbench
=====================================

// Module: data_mem_responder
// PURPOSE
// - Responder end of the RV32I core's LOAD/STORE data-memory interface.
//   The core's load/store stage is the initiator.
// - Accepts one request at a time: byte/half/word, funct3 encoded as LOAD_STORE_FNS::funct3_t.
// - Word-organised RAM with configurable wait states; little-endian lane select;
//   sign/zero extension of loads done here.
// - Memory-mapped OUTPORT (OUTPORT_ADDR) and INPORT (INPORT_ADDR) word registers.
// PARAMETERS
// MEM_WORDS     1024          RAM depth in 32-bit words; RAM byte range 0 .. 4*MEM_WORDS-1
// WAIT_STATES   1             extra cycles between accept and response, 0..7
// OUTPORT_ADDR  32'h0000fffc  byte address of output port register
// INPORT_ADDR   32'h0000fff8  byte address of input port (read-only)
// PORTS
// clk         in   1   clock, all state on rising edge
// rst         in   1   reset, asynchronous, active-high
// req_valid   in   1   request present
// req_ready   out  1   responder can accept; transfer when req_valid & req_ready
// req_we      in   1   1 = store, 0 = load
// req_addr    in   32  byte address
// req_funct3  in   3   width/sign: BYTE, HALF, WORD, BYTE_U, HALF_U
// req_wdata   in   32  store data, right-aligned (byte in [7:0], half in [15:0])
// rsp_valid   out  1   response present; held until rsp_ready
// rsp_ready   in   1   initiator accepts response
// rsp_rdata   out  32  load data, extended per funct3; 0 for stores and errors
// rsp_err     out  1   misaligned, illegal funct3, or unmapped address
// outport     out  32  output port register
// inport      in   32  input port, already synchronous to clk
// BEHAVIOUR
// - Reset values:
//   - state IDLE; req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, outport=0.
//   - RAM contents are not reset.
// - FSM:
//   - IDLE: req_ready=1. On accept, capture we/addr/funct3/wdata; load wait counter = WAIT_STATES.
//     Next state: WAIT if WAIT_STATES>0, else RESP.
//   - WAIT: req_ready=0. Counter decrements each cycle; at 1 -> RESP.
//   - RESP: req_ready=0, rsp_valid=1; rsp_rdata/rsp_err stable until handshake.
//     rsp_valid & rsp_ready -> IDLE.
// - Latency: accept at edge N -> rsp_valid high in cycle N+1+WAIT_STATES. Minimum 2 cycles
//   per transaction; no accept in the same cycle as a response handshake.
// - Commit: store write / OUTPORT update / load data capture happen on the edge that enters
//   RESP. A load issued after a store's response sees the new data.
// - Errors: rsp_err=1, rdata=0, no state change, for any of:
//   - HALF/HALF_U with addr[0]!=0; WORD with addr[1:0]!=0.
//   - funct3 in {011,110,111}; store with funct3 BYTE_U/HALF_U.
//   - addr >= 4*MEM_WORDS and addr not a port address.
//   - non-WORD access to either port; store to INPORT_ADDR.
// - Loads, lane = addr[1:0]:
//   - BYTE: sign-extend byte[lane]. BYTE_U: zero-extend byte[lane].
//   - HALF: sign-extend half[addr[1]]. HALF_U: zero-extend half[addr[1]].
//   - WORD: full word.
// - Stores: byte enables derived from funct3/lane; wdata replicated to lanes; untouched bytes preserved.
// - Ports:
//   - LW OUTPORT_ADDR returns the current outport value.
//   - LW INPORT_ADDR returns inport sampled on the commit edge.
// - Address bits above log2(4*MEM_WORDS) must be zero for RAM hits (no aliasing).
// - Reset mid-operation: returns to IDLE immediately. A store still in WAIT has no effect.
//   An in-flight response is dropped.
// - req_* inputs are ignored outside IDLE.
// STRUCTURE
// - Package LOAD_STORE_FNS gains: INPORT_ADDR localparam and
//   typedef enum logic [1:0] {MEM_IDLE, MEM_WAIT, MEM_RESP} mem_state_t.
//   Reuse funct3_t and OUTPORT_ADDR from the same package.
// - Sub-module byte_en_ram (MEM_WORDS x 32, 4 byte enables, sync write, async read).
//   Holds the storage; alignment/extension logic and the FSM stay in this module.
// TESTING
// - Reset: rst pulsed mid-cycle -> immediately req_ready=1, rsp_valid=0, outport=0, rsp_err=0.
// - SW 0x10 <- 0xDEADBEEF, then loads (rsp_err=0 on each):
//   LB 0x13 -> 0xFFFFFFDE; LBU 0x10 -> 0x000000EF; LH 0x12 -> 0xFFFFDEAD; LHU 0x10 -> 0x0000BEEF.
// - SB 0x11 <- 0x00000055, then LW 0x10 -> 0xDEAD55EF; SH 0x12 <- 0x1234, then LW 0x10 -> 0x123455EF.
// - Error cases, each -> rsp_err=1, rdata=0, RAM unchanged (check with LW 0x0):
//   LW 0x2; SH 0x1; LW 0x1000; funct3=011; SB 0xfffc.
// - SW 0xfffc <- 0x12345678 -> outport=0x12345678 in the rsp_valid cycle;
//   LW 0xfffc -> 0x12345678; inport=0xA5A5A5A5, LW 0xfff8 -> 0xA5A5A5A5.
// - WAIT_STATES=3: accept at N -> rsp_valid at N+4. Hold rsp_ready=0 for 2 cycles ->
//   rsp_valid/rdata stable, req_ready=0. rst during WAIT of SW 0x20 <- 0xFFFFFFFF ->
//   subsequent LW 0x20 returns the old value.

Source files
------------

// File: rtl/data_mem_responder_pkg.sv
// Shared load/store encodings, port addresses and the responder's state/request types.
// Imported by the data-memory responder and its storage.
package LOAD_STORE_FNS;

    typedef enum logic [2:0] {
        BYTE   = 3'b000,
        HALF   = 3'b001,
        WORD   = 3'b010,
        BYTE_U = 3'b100,
        HALF_U = 3'b101
    } funct3_t;

    localparam logic [31:0] OUTPORT_ADDR = 32'h0000_fffc;
    localparam logic [31:0] INPORT_ADDR  = 32'h0000_fff8;

    typedef enum logic [1:0] {MEM_IDLE, MEM_WAIT, MEM_RESP} mem_state_t;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [2:0]  funct3;
        logic [31:0] wdata;
    } mem_req_t;

    // Pick the addressed lane out of a little-endian word and extend it per funct3.
    function automatic logic [31:0] extend_load(input logic [31:0] word,
                                                input logic [1:0]  lane,
                                                input logic [2:0]  f3);
        logic [7:0]  b;
        logic [15:0] h;
        b = 8'(word >> {lane, 3'b000});
        h = lane[1] ? word[31:16] : word[15:0];
        case (f3)
            BYTE:    extend_load = {{24{b[7]}}, b};
            BYTE_U:  extend_load = {24'h0, b};
            HALF:    extend_load = {{16{h[15]}}, h};
            HALF_U:  extend_load = {16'h0, h};
            default: extend_load = word;
        endcase
    endfunction

endpackage

// File: rtl/data_mem_responder_ram.sv
// Word-organised storage with per-byte write enables; synchronous write, asynchronous read.
module byte_en_ram #(
    parameter int unsigned WORDS = 1024,
    parameter int unsigned AW    = 10
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [3:0]    be_i,
    input  logic [AW-1:0] addr_i,
    input  logic [31:0]   wdata_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem_q [WORDS];

    always_ff @(posedge clk) begin
        if (we_i) begin
            for (int i = 0; i < 4; i++) begin
                if (be_i[i]) mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
            end
        end
    end

    assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/data_mem_responder.sv
// Responder for the core's load/store data-memory interface: RAM plus word-wide in/out ports,
// one request at a time with a fixed number of wait states before the response.
module data_mem_responder #(
    parameter int unsigned MEM_WORDS    = 1024,
    parameter int unsigned WAIT_STATES  = 1,
    parameter logic [31:0] OUTPORT_ADDR = LOAD_STORE_FNS::OUTPORT_ADDR,
    parameter logic [31:0] INPORT_ADDR  = LOAD_STORE_FNS::INPORT_ADDR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [31:0] outport,
    input  logic [31:0] inport
);
    import LOAD_STORE_FNS::*;

    localparam int unsigned AW        = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam logic [31:0] RAM_BYTES = 32'(4 * MEM_WORDS);

    mem_state_t  state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    mem_req_t    req_q, req_d, acc;
    logic        ready_q, ready_d, valid_q, valid_d, err_q, err_d;
    logic [31:0] rdata_q, rdata_d, outport_q, outport_d;

    logic        out_hit, in_hit, ram_hit, acc_err, commit, ram_we;
    logic [3:0]  be;
    logic [31:0] wword, ram_rdata, ld_word;

    // In IDLE the commit (zero wait states) uses the live request; otherwise the captured one.
    always_comb begin
        acc = req_q;
        if (state_q == MEM_IDLE) begin
            acc.we     = req_we;
            acc.addr   = req_addr;
            acc.funct3 = req_funct3;
            acc.wdata  = req_wdata;
        end
    end

    // Address decode, byte enables and error classification.
    always_comb begin
        out_hit = (acc.addr == OUTPORT_ADDR);
        in_hit  = (acc.addr == INPORT_ADDR);
        ram_hit = !out_hit && !in_hit && (acc.addr < RAM_BYTES);
        acc_err = 1'b0;
        be      = 4'b0000;
        wword   = acc.wdata;
        case (acc.funct3)
            BYTE, BYTE_U: begin
                be    = 4'b0001 << acc.addr[1:0];
                wword = {4{acc.wdata[7:0]}};
            end
            HALF, HALF_U: begin
                acc_err = acc.addr[0];
                be      = acc.addr[1] ? 4'b1100 : 4'b0011;
                wword   = {2{acc.wdata[15:0]}};
            end
            WORD: begin
                acc_err = (acc.addr[1:0] != 2'b00);
                be      = 4'b1111;
            end
            default: acc_err = 1'b1;
        endcase
        if (acc.we && acc.funct3[2]) acc_err = 1'b1;
        if ((out_hit || in_hit) && ((acc.funct3 != WORD) || (in_hit && acc.we))) acc_err = 1'b1;
        if (!out_hit && !in_hit && !ram_hit) acc_err = 1'b1;
    end

    assign ld_word = in_hit ? inport : (out_hit ? outport_q : ram_rdata);

    // Next state and registered response/port values.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        req_d     = req_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        outport_d = outport_q;
        case (state_q)
            MEM_IDLE: begin
                if (req_valid) begin
                    req_d   = acc;
                    cnt_d   = 3'(WAIT_STATES);
                    state_d = (WAIT_STATES != 0) ? MEM_WAIT : MEM_RESP;
                end
            end
            MEM_WAIT: begin
                if (cnt_q <= 3'd1) state_d = MEM_RESP;
                else               cnt_d   = cnt_q - 3'd1;
            end
            MEM_RESP: begin
                if (rsp_ready) state_d = MEM_IDLE;
            end
            default: state_d = MEM_IDLE;
        endcase
        commit = (state_d == MEM_RESP) && (state_q != MEM_RESP);
        if (commit) begin
            err_d   = acc_err;
            rdata_d = (acc_err || acc.we) ? 32'h0 : extend_load(ld_word, acc.addr[1:0], acc.funct3);
            if (acc.we && !acc_err && out_hit) outport_d = acc.wdata;
        end
        ready_d = (state_d == MEM_IDLE);
        valid_d = (state_d == MEM_RESP);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= MEM_IDLE;
            cnt_q     <= 3'd0;
            req_q     <= '0;
            ready_q   <= 1'b1;
            valid_q   <= 1'b0;
            rdata_q   <= 32'h0;
            err_q     <= 1'b0;
            outport_q <= 32'h0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            req_q     <= req_d;
            ready_q   <= ready_d;
            valid_q   <= valid_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
            outport_q <= outport_d;
        end
    end

    // Gated by rst so a reset landing on a commit edge cannot leave a partial store behind.
    assign ram_we = commit && acc.we && !acc_err && ram_hit && !rst;

    byte_en_ram #(.WORDS(MEM_WORDS), .AW(AW)) u_ram (
        .clk     (clk),
        .we_i    (ram_we),
        .be_i    (be),
        .addr_i  (acc.addr[AW+1:2]),
        .wdata_i (wword),
        .rdata_o (ram_rdata)
    );

    assign req_ready = ready_q;
    assign rsp_valid = valid_q;
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;
    assign outport   = outport_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: byte-addressed reference model, per-cycle output compare,
// directed literal checks and randomized traffic.
module tb_data_mem_responder;

    localparam int unsigned W         = 3;
    localparam logic [31:0] OUT_A     = 32'h0000_fffc;
    localparam logic [31:0] IN_A      = 32'h0000_fff8;
    localparam int unsigned RAM_BYTES = 4096;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0, req_ready, req_we = 1'b0;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic [2:0]  req_funct3 = '0;
    logic        rsp_valid, rsp_ready = 1'b0, rsp_err;
    logic [31:0] rsp_rdata, outport, inport = '0;

    int total = 0;
    int bad   = 0;
    bit started = 1'b0;

    data_mem_responder #(.MEM_WORDS(1024), .WAIT_STATES(W)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_funct3(req_funct3), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .outport(outport), .inport(inport)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", nm, got, exp, $time);
        end
    endtask

    // Reference model: byte memory, one outstanding transaction, response after W edges.
    logic [7:0]  mem_m [0:255];
    bit          pending = 1'b0;
    int          k = 0;
    logic        t_we;
    logic [31:0] t_addr, t_wdata;
    logic [2:0]  t_f3;
    logic [31:0] exp_rdata, out_cur = '0, out_next = '0;
    logic        exp_err;

    task automatic model_commit();
        int   n;
        bit   legal, is_port;
        logic [31:0] v;
        n       = 1 << t_f3[1:0];
        legal   = (t_f3 == 3'd0) || (t_f3 == 3'd1) || (t_f3 == 3'd2) || (t_f3 == 3'd4) || (t_f3 == 3'd5);
        is_port = (t_addr == OUT_A) || (t_addr == IN_A);
        out_next = out_cur;
        exp_err = !legal || (t_we && t_f3[2]) || ((t_addr % n) != 0)
                  || (is_port && (n != 4 || (t_we && t_addr == IN_A)))
                  || (!is_port && t_addr >= RAM_BYTES);
        exp_rdata = '0;
        if (!exp_err) begin
            if (t_we) begin
                if (t_addr == OUT_A) out_next = t_wdata;
                else for (int i = 0; i < n; i++) mem_m[t_addr[7:0] + 8'(i)] = t_wdata[8*i +: 8];
            end else begin
                if (t_addr == OUT_A)      v = out_cur;
                else if (t_addr == IN_A)  v = inport;
                else begin
                    v = '0;
                    for (int i = 0; i < n; i++) v = v | (32'(mem_m[t_addr[7:0] + 8'(i)]) << (8*i));
                end
                if (!t_f3[2] && n < 4 && v[8*n-1]) v = v | (32'hffff_ffff << (8*n));
                exp_rdata = v;
            end
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            pending  = 1'b0;
            k        = 0;
            out_cur  = '0;
            out_next = '0;
        end else if (pending) begin
            if (k >= W) begin
                if (rsp_ready) begin
                    pending = 1'b0;
                    out_cur = out_next;
                end
            end else begin
                k++;
                if (k == W) model_commit();
            end
        end else if (req_valid) begin
            pending = 1'b1;
            k       = 0;
            t_we = req_we; t_addr = req_addr; t_f3 = req_funct3; t_wdata = req_wdata;
            if (k == W) model_commit();
        end
    end

    // Per-cycle comparison of every DUT output against the model.
    always @(negedge clk) begin
        if (started && !rst) begin
            chk("cmp_req_ready", 32'(req_ready), 32'(!pending));
            chk("cmp_rsp_valid", 32'(rsp_valid), 32'(pending && k >= W));
            if (pending && k >= W) begin
                chk("cmp_rsp_rdata", rsp_rdata, exp_rdata);
                chk("cmp_rsp_err", 32'(rsp_err), 32'(exp_err));
            end
            chk("cmp_outport", outport, (pending && k >= W) ? out_next : out_cur);
        end
    end

    logic [31:0] out_at_valid;

    task automatic issue(input logic we, input logic [31:0] a, input logic [2:0] f, input logic [31:0] wd,
                         input int hold, output logic [31:0] rd, output logic er, output int lat);
        int n;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_addr = a; req_funct3 = f; req_wdata = wd;
        @(negedge clk);
        n = 0;
        while (!rsp_valid && n < 40) begin
            req_valid = 1'($urandom); req_we = 1'($urandom); req_addr = $urandom;
            req_funct3 = 3'($urandom); req_wdata = $urandom;
            @(negedge clk);
            n++;
        end
        if (!rsp_valid) chk("rsp_timeout", 32'(rsp_valid), 32'd1);
        lat = n;
        rd  = rsp_rdata;
        er  = rsp_err;
        out_at_valid = outport;
        for (int i = 0; i < hold; i++) begin
            req_valid = 1'($urandom); req_addr = $urandom;
            @(negedge clk);
            chk("hold_rdata", rsp_rdata, rd);
            chk("hold_valid", 32'(rsp_valid), 32'd1);
            chk("hold_req_ready", 32'(req_ready), 32'd0);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic ld(input string nm, input logic [2:0] f, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] rd; logic er; int lat;
        issue(1'b0, a, f, 32'h0, 0, rd, er, lat);
        chk(nm, rd, exp);
        chk({nm, "_err"}, 32'(er), 32'd0);
    endtask

    task automatic st(input string nm, input logic [2:0] f, input logic [31:0] a, input logic [31:0] wd);
        logic [31:0] rd; logic er; int lat;
        issue(1'b1, a, f, wd, 0, rd, er, lat);
        chk({nm, "_err"}, 32'(er), 32'd0);
    endtask

    task automatic bad_acc(input string nm, input logic we, input logic [2:0] f, input logic [31:0] a);
        logic [31:0] rd; logic er; int lat;
        issue(we, a, f, 32'hffff_ffff, 0, rd, er, lat);
        chk({nm, "_err"}, 32'(er), 32'd1);
        chk({nm, "_rdata"}, rd, 32'h0);
    endtask

    task automatic pulse_rst();
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_outport", outport, 32'h0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);
        #1 rst = 1'b0;
    endtask

    initial begin
        logic [31:0] rd, a;
        logic er;
        int lat, r;

        repeat (3) @(negedge clk);
        chk("init_req_ready", 32'(req_ready), 32'd1);
        chk("init_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("init_outport", outport, 32'h0);
        #2 rst = 1'b0;
        started = 1'b1;

        st("sw0", 3'b010, 32'h0, 32'hCAFE_F00D);
        st("sw10", 3'b010, 32'h10, 32'hDEAD_BEEF);
        issue(1'b0, 32'h13, 3'b000, 32'h0, 2, rd, er, lat);
        chk("lb13", rd, 32'hFFFF_FFDE);
        chk("lb13_latency", 32'(lat), 32'd3);
        ld("lbu10", 3'b100, 32'h10, 32'h0000_00EF);
        ld("lh12", 3'b001, 32'h12, 32'hFFFF_DEAD);
        ld("lhu10", 3'b101, 32'h10, 32'h0000_BEEF);

        st("sb11", 3'b000, 32'h11, 32'h0000_0055);
        ld("lw10_a", 3'b010, 32'h10, 32'hDEAD_55EF);
        st("sh12", 3'b001, 32'h12, 32'h0000_1234);
        ld("lw10_b", 3'b010, 32'h10, 32'h1234_55EF);

        bad_acc("lw2", 1'b0, 3'b010, 32'h2);
        bad_acc("sh1", 1'b1, 3'b001, 32'h1);
        bad_acc("lw1000", 1'b0, 3'b010, 32'h1000);
        bad_acc("f3_011", 1'b0, 3'b011, 32'h0);
        bad_acc("sb_out", 1'b1, 3'b000, OUT_A);
        bad_acc("sw_in", 1'b1, 3'b010, IN_A);
        ld("lw0_intact", 3'b010, 32'h0, 32'hCAFE_F00D);
        chk("outport_untouched", outport, 32'h0);

        issue(1'b1, OUT_A, 3'b010, 32'h1234_5678, 0, rd, er, lat);
        chk("sw_out_at_valid", out_at_valid, 32'h1234_5678);
        ld("lw_out", 3'b010, OUT_A, 32'h1234_5678);
        inport = 32'hA5A5_A5A5;
        ld("lw_in", 3'b010, IN_A, 32'hA5A5_A5A5);

        st("sw20", 3'b010, 32'h20, 32'h0BAD_F00D);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_funct3 = 3'b010; req_wdata = 32'hFFFF_FFFF;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        pulse_rst();
        ld("lw20_after_rst", 3'b010, 32'h20, 32'h0BAD_F00D);

        for (int i = 0; i < 64; i++) st("init", 3'b010, 32'(4 * i), $urandom);
        for (int i = 0; i < 300; i++) begin
            inport = $urandom;
            r = $urandom_range(0, 9);
            if (r < 8)       a = 32'($urandom_range(0, 255));
            else if (r == 8) a = ($urandom_range(0, 1) != 0) ? OUT_A : IN_A;
            else             a = $urandom | 32'h0001_0000;
            issue(1'($urandom), a, 3'($urandom), $urandom, $urandom_range(0, 2), rd, er, lat);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog t=%0t total=%0d bad=%0d", $time, total, bad);
        $fatal(1, "watchdog");
    end

endmodule
